pep_ks_batch_seq: RTL and testbench



---
 rtl/pep_ks_batch_seq.sv | 172 +++++++++++++++++
 tb/tb_pep_ks_batch_seq.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pep_ks_batch_seq.sv
// pep_ks_batch_seq: batch sequencer for the key-switch processing array.
// Takes one batch command at a time, reserves an output-FIFO slot for it, and
// walks every (line block, level group, PBS) position of the selected column
// block, emitting one control beat per position to the MAC datapath.
module pep_ks_batch_seq #(
    parameter  int LBX              = 2,
    parameter  int LBY              = 2,
    parameter  int LBZ              = 1,
    parameter  int BLWE_K           = 5,
    parameter  int LWE_K_P1         = 7,
    parameter  int KS_L             = 3,
    parameter  int BATCH_PBS_MAX    = 8,
    parameter  int OUT_FIFO_DEPTH   = 4,
    localparam int KS_BLOCK_LINE_NB = (BLWE_K + LBY - 1) / LBY,
    localparam int KS_BLOCK_COL_NB  = (LWE_K_P1 + LBX - 1) / LBX,
    localparam int KS_LG_NB         = (KS_L + LBZ - 1) / LBZ,
    localparam int KS_BLOCK_LINE_W  = (KS_BLOCK_LINE_NB > 1) ? $clog2(KS_BLOCK_LINE_NB) : 1,
    localparam int KS_BLOCK_COL_W   = (KS_BLOCK_COL_NB > 1) ? $clog2(KS_BLOCK_COL_NB) : 1,
    localparam int KS_LG_W          = (KS_LG_NB > 1) ? $clog2(KS_LG_NB) : 1,
    localparam int PBS_NB_W         = $clog2(BATCH_PBS_MAX + 1),
    localparam int PBS_ID_W         = (BATCH_PBS_MAX > 1) ? $clog2(BATCH_PBS_MAX) : 1,
    localparam int OUT_FIFO_DEPTH_W = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1
) (
    input  logic                        clk,
    input  logic                        s_rst_n,
    input  logic                        cmd_vld,
    output logic                        cmd_rdy,
    input  logic [PBS_NB_W-1:0]         cmd_pbs_nb,
    input  logic [KS_BLOCK_COL_W-1:0]   cmd_ks_loop,
    output logic                        proc_vld,
    input  logic                        proc_rdy,
    output logic [PBS_ID_W-1:0]         proc_pbs_id,
    output logic [KS_BLOCK_LINE_W-1:0]  proc_line_blk,
    output logic [KS_LG_W-1:0]          proc_lg,
    output logic [KS_BLOCK_COL_W-1:0]   proc_col_blk,
    output logic                        proc_first,
    output logic                        proc_last_pbs,
    output logic                        proc_last,
    input  logic                        out_free,
    output logic                        batch_done,
    output logic [OUT_FIFO_DEPTH_W:0]   credit
);

    localparam logic [KS_BLOCK_LINE_W-1:0]  LINE_MAX   = KS_BLOCK_LINE_W'(KS_BLOCK_LINE_NB - 1);
    localparam logic [KS_LG_W-1:0]          LG_MAX     = KS_LG_W'(KS_LG_NB - 1);
    localparam logic [PBS_NB_W-1:0]         PBS_NB_MAX = PBS_NB_W'(BATCH_PBS_MAX);
    localparam logic [OUT_FIFO_DEPTH_W:0]   CREDIT_MAX = (OUT_FIFO_DEPTH_W + 1)'(OUT_FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t                       state_q, state_d;
    logic [PBS_NB_W-1:0]          pbs_nb_q, pbs_nb_d;
    logic [KS_BLOCK_COL_W-1:0]    col_blk_q, col_blk_d;
    logic [PBS_ID_W-1:0]          pbs_id_q, pbs_id_d;
    logic [KS_BLOCK_LINE_W-1:0]   line_blk_q, line_blk_d;
    logic [KS_LG_W-1:0]           lg_q, lg_d;
    logic [OUT_FIFO_DEPTH_W:0]    credit_q, credit_d;

    logic cmd_acc;
    logic cmd_take;
    logic pbs_at_last;
    logic lg_at_last;
    logic line_at_last;
    logic run;

    // Status decode and beat outputs; everything here depends on flops only,
    // except the reset gate on cmd_rdy so nothing is accepted while in reset.
    always_comb begin
        run           = (state_q == ST_RUN);
        pbs_at_last   = (PBS_NB_W'(pbs_id_q) == (pbs_nb_q - PBS_NB_W'(1)));
        lg_at_last    = (lg_q == LG_MAX);
        line_at_last  = (line_blk_q == LINE_MAX);
        cmd_rdy       = s_rst_n && (state_q == ST_IDLE) && (credit_q != '0);
        proc_vld      = run;
        proc_pbs_id   = pbs_id_q;
        proc_line_blk = line_blk_q;
        proc_lg       = lg_q;
        proc_col_blk  = col_blk_q;
        proc_first    = run && (pbs_id_q == '0) && (lg_q == '0) && (line_blk_q == '0);
        proc_last_pbs = run && pbs_at_last;
        proc_last     = run && pbs_at_last && lg_at_last && line_at_last;
        batch_done    = (state_q == ST_DONE);
        credit        = credit_q;
    end

    // Next-state logic: command latch, position walk and slot credit.
    always_comb begin
        state_d    = state_q;
        pbs_nb_d   = pbs_nb_q;
        col_blk_d  = col_blk_q;
        pbs_id_d   = pbs_id_q;
        line_blk_d = line_blk_q;
        lg_d       = lg_q;
        credit_d   = credit_q;
        cmd_acc    = cmd_vld && cmd_rdy;
        cmd_take   = cmd_acc && (cmd_pbs_nb != '0);

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_acc) begin
                    pbs_nb_d   = (cmd_pbs_nb > PBS_NB_MAX) ? PBS_NB_MAX : cmd_pbs_nb;
                    col_blk_d  = cmd_ks_loop;
                    pbs_id_d   = '0;
                    lg_d       = '0;
                    line_blk_d = '0;
                    state_d    = (cmd_pbs_nb == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (proc_rdy) begin
                    if (!pbs_at_last) begin
                        pbs_id_d = pbs_id_q + PBS_ID_W'(1);
                    end else begin
                        pbs_id_d = '0;
                        if (!lg_at_last) begin
                            lg_d = lg_q + KS_LG_W'(1);
                        end else begin
                            lg_d = '0;
                            if (!line_at_last) begin
                                line_blk_d = line_blk_q + KS_BLOCK_LINE_W'(1);
                            end else begin
                                line_blk_d = '0;
                                state_d    = ST_DONE;
                            end
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A slot taken and a slot freed in the same cycle cancel out; a free
        // with every slot already free is a no-op.
        unique case ({cmd_take, out_free})
            2'b10:   credit_d = credit_q - (OUT_FIFO_DEPTH_W + 1)'(1);
            2'b01:   credit_d = (credit_q == CREDIT_MAX) ? credit_q
                                                         : credit_q + (OUT_FIFO_DEPTH_W + 1)'(1);
            default: credit_d = credit_q;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            state_q    <= ST_IDLE;
            pbs_nb_q   <= '0;
            col_blk_q  <= '0;
            pbs_id_q   <= '0;
            line_blk_q <= '0;
            lg_q       <= '0;
            credit_q   <= CREDIT_MAX;
        end else begin
            state_q    <= state_d;
            pbs_nb_q   <= pbs_nb_d;
            col_blk_q  <= col_blk_d;
            pbs_id_q   <= pbs_id_d;
            line_blk_q <= line_blk_d;
            lg_q       <= lg_d;
            credit_q   <= credit_d;
        end
    end

endmodule

// File: tb/tb_pep_ks_batch_seq.sv
// tb_pep_ks_batch_seq: self-checking bench for pep_ks_batch_seq at default
// parameters. A queue model of the expected beat stream, credit and done pulse
// is compared against the DUT every cycle; directed tests add literal checks.
module tb_pep_ks_batch_seq;

    localparam int LINE_NB = (5 + 2 - 1) / 2;
    localparam int LG_NB   = (3 + 1 - 1) / 1;
    localparam int PBS_MAX = 8;
    localparam int DEPTH   = 4;

    logic       clk;
    logic       s_rst_n;
    logic       cmd_vld;
    logic       cmd_rdy;
    logic [3:0] cmd_pbs_nb;
    logic [1:0] cmd_ks_loop;
    logic       proc_vld;
    logic       proc_rdy;
    logic [2:0] proc_pbs_id;
    logic [1:0] proc_line_blk;
    logic [1:0] proc_lg;
    logic [1:0] proc_col_blk;
    logic       proc_first;
    logic       proc_last_pbs;
    logic       proc_last;
    logic       out_free;
    logic       batch_done;
    logic [2:0] credit;

    pep_ks_batch_seq dut (
        .clk           (clk),
        .s_rst_n       (s_rst_n),
        .cmd_vld       (cmd_vld),
        .cmd_rdy       (cmd_rdy),
        .cmd_pbs_nb    (cmd_pbs_nb),
        .cmd_ks_loop   (cmd_ks_loop),
        .proc_vld      (proc_vld),
        .proc_rdy      (proc_rdy),
        .proc_pbs_id   (proc_pbs_id),
        .proc_line_blk (proc_line_blk),
        .proc_lg       (proc_lg),
        .proc_col_blk  (proc_col_blk),
        .proc_first    (proc_first),
        .proc_last_pbs (proc_last_pbs),
        .proc_last     (proc_last),
        .out_free      (out_free),
        .batch_done    (batch_done),
        .credit        (credit)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        int pbs;
        int line;
        int lg;
        int col;
        bit first;
        bit lastpbs;
        bit last;
    } beat_t;

    beat_t q[$];
    int    m_credit = DEPTH;
    bit    m_done   = 1'b0;
    bit    m_live   = 1'b0;
    bit    m_acc;

    int beat_cnt;
    int first_cnt;
    int last_cnt;
    int col_bad;
    int log_line [0:127];
    int log_lg   [0:127];
    int log_pbs  [0:127];
    int log_first[0:127];
    int accept_cyc;
    int done_cyc;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // The whole batch as a flat ordered list: line block outermost, PBS innermost.
    task automatic pushBatch(input int nb, input int col);
        int k;
        int total;
        beat_t b;
        k = 0;
        total = LINE_NB * LG_NB * nb;
        for (int l = 0; l < LINE_NB; l++)
            for (int g = 0; g < LG_NB; g++)
                for (int p = 0; p < nb; p++) begin
                    b.pbs     = p;
                    b.line    = l;
                    b.lg      = g;
                    b.col     = col;
                    b.first   = (k == 0);
                    b.lastpbs = (p == nb - 1);
                    b.last    = (k == total - 1);
                    q.push_back(b);
                    k++;
                end
    endtask

    function automatic bit modelRdy();
        return s_rst_n && (q.size() == 0) && !m_done && (m_credit != 0);
    endfunction

    // Model update at each active edge from the inputs the DUT samples there.
    always @(posedge clk) begin
        cyc++;
        if (!s_rst_n) begin
            q.delete();
            m_credit = DEPTH;
            m_done   = 1'b0;
            m_live   = 1'b1;
        end else if (m_live) begin
            m_acc  = cmd_vld && modelRdy();
            m_done = 1'b0;
            if (q.size() != 0 && proc_rdy) begin
                if (q[0].last) m_done = 1'b1;
                void'(q.pop_front());
            end
            if (m_acc && cmd_pbs_nb != 0 && out_free) begin
                m_credit = m_credit;
            end else if (m_acc && cmd_pbs_nb != 0) begin
                m_credit = m_credit - 1;
            end else if (out_free && m_credit < DEPTH) begin
                m_credit = m_credit + 1;
            end
            if (m_acc) begin
                if (cmd_pbs_nb == 0) m_done = 1'b1;
                else pushBatch((cmd_pbs_nb > PBS_MAX) ? PBS_MAX : int'(cmd_pbs_nb), int'(cmd_ks_loop));
            end
        end
    end

    // Per-cycle comparison of every output against the model, plus a beat log.
    always @(negedge clk) begin
        if (m_live) begin
            checkOutput("cmd_rdy", cmd_rdy, modelRdy());
            checkOutput("proc_vld", proc_vld, q.size() != 0);
            checkOutput("batch_done", batch_done, m_done);
            checkOutput("credit", credit, m_credit);
            if (q.size() != 0) begin
                checkOutput("proc_pbs_id", proc_pbs_id, q[0].pbs);
                checkOutput("proc_line_blk", proc_line_blk, q[0].line);
                checkOutput("proc_lg", proc_lg, q[0].lg);
                checkOutput("proc_col_blk", proc_col_blk, q[0].col);
                checkOutput("proc_first", proc_first, q[0].first);
                checkOutput("proc_last_pbs", proc_last_pbs, q[0].lastpbs);
                checkOutput("proc_last", proc_last, q[0].last);
            end
        end
        if (proc_vld && proc_rdy && beat_cnt < 128) begin
            log_line[beat_cnt]  = proc_line_blk;
            log_lg[beat_cnt]    = proc_lg;
            log_pbs[beat_cnt]   = proc_pbs_id;
            log_first[beat_cnt] = proc_first;
            if (proc_first) first_cnt++;
            if (proc_last) last_cnt++;
            beat_cnt++;
        end
    end

    // Hard stop in case some wait below were ever left unbounded.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got %0d vectors", n_vec);
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearLog();
        beat_cnt  = 0;
        first_cnt = 0;
        last_cnt  = 0;
        col_bad   = 0;
    endtask

    task automatic applyStimulus(input logic [3:0] nb, input logic [1:0] loop, input int budget);
        bit got;
        got = 1'b0;
        cmd_pbs_nb  = nb;
        cmd_ks_loop = loop;
        cmd_vld     = 1'b1;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (cmd_rdy) begin
                got = 1'b1;
                accept_cyc = cyc;
            end
            tick();
        end
        cmd_vld = 1'b0;
        checkOutput("cmd_accepted", got, 1);
    endtask

    task automatic waitDone(input int budget, input bit toggle);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (batch_done) begin
                seen = 1'b1;
                done_cyc = cyc;
            end
            tick();
            if (toggle) proc_rdy = ~proc_rdy;
        end
        proc_rdy = 1'b1;
        checkOutput("batch_done_seen", seen, 1);
    endtask

    task automatic freeSlot();
        out_free = 1'b1;
        tick();
        out_free = 1'b0;
    endtask

    // Directed sequence with literal expectations pinning the model.
    initial begin
        s_rst_n     = 1'b0;
        cmd_vld     = 1'b0;
        cmd_pbs_nb  = '0;
        cmd_ks_loop = '0;
        proc_rdy    = 1'b1;
        out_free    = 1'b0;
        clearLog();
        tick();
        tick();
        @(negedge clk);
        checkOutput("rst_credit", credit, 4);
        checkOutput("rst_proc_vld", proc_vld, 0);
        checkOutput("rst_cmd_rdy", cmd_rdy, 0);
        checkOutput("rst_batch_done", batch_done, 0);
        checkOutput("rst_flags", {proc_first, proc_last_pbs, proc_last}, 0);
        checkOutput("rst_index", {proc_pbs_id, proc_line_blk, proc_lg}, 0);
        tick();
        s_rst_n = 1'b1;

        // Single batch, datapath always ready.
        clearLog();
        applyStimulus(4'd2, 2'd3, 10);
        waitDone(40, 1'b0);
        checkOutput("t1_beats", beat_cnt, 18);
        checkOutput("t1_latency", done_cyc - accept_cyc, 19);
        checkOutput("t1_first_cnt", first_cnt, 1);
        checkOutput("t1_last_cnt", last_cnt, 1);
        checkOutput("t1_beat1", {log_line[0], log_lg[0], log_pbs[0], log_first[0]}, {32'd0, 32'd0, 32'd0, 32'd1});
        checkOutput("t1_beat2", {log_line[1], log_lg[1], log_pbs[1]}, {32'd0, 32'd0, 32'd1});
        checkOutput("t1_beat3", {log_line[2], log_lg[2], log_pbs[2]}, {32'd0, 32'd1, 32'd0});
        checkOutput("t1_beat18", {log_line[17], log_lg[17], log_pbs[17]}, {32'd2, 32'd2, 32'd1});
        @(negedge clk);
        checkOutput("t1_credit", credit, 3);
        tick();
        freeSlot();

        // Same batch with the datapath ready every other cycle.
        clearLog();
        applyStimulus(4'd2, 2'd3, 10);
        proc_rdy = 1'b1;
        waitDone(80, 1'b1);
        checkOutput("t2_beats", beat_cnt, 18);
        checkOutput("t2_latency", done_cyc - accept_cyc, 36);
        freeSlot();

        // Exhaust all four slots, then a single free lets the fifth in.
        for (int b = 0; b < 4; b++) begin
            applyStimulus(4'd1, 2'd0, 10);
            waitDone(30, 1'b0);
        end
        @(negedge clk);
        checkOutput("t3_credit_empty", credit, 0);
        tick();
        cmd_pbs_nb = 4'd1;
        cmd_vld    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("t3_blocked_rdy", cmd_rdy, 0);
            tick();
        end
        out_free = 1'b1;
        tick();
        out_free = 1'b0;
        @(negedge clk);
        checkOutput("t3_release_rdy", cmd_rdy, 1);
        accept_cyc = cyc;
        tick();
        cmd_vld = 1'b0;
        waitDone(30, 1'b0);
        checkOutput("t3_latency", done_cyc - accept_cyc, 10);

        // Accept and free in the same cycle leave credit unchanged; free at full saturates.
        freeSlot();
        freeSlot();
        freeSlot();
        out_free = 1'b1;
        applyStimulus(4'd1, 2'd1, 10);
        out_free = 1'b0;
        @(negedge clk);
        checkOutput("t4_credit_same_cycle", credit, 3);
        tick();
        waitDone(30, 1'b0);
        freeSlot();
        freeSlot();
        @(negedge clk);
        checkOutput("t4_credit_saturate", credit, 4);
        tick();

        // Empty batch: immediate completion, no beats, no slot used.
        clearLog();
        applyStimulus(4'd0, 2'd1, 10);
        waitDone(10, 1'b0);
        checkOutput("t5_latency", done_cyc - accept_cyc, 1);
        checkOutput("t5_beats", beat_cnt, 0);
        checkOutput("t5_credit", credit, 4);

        // Oversized batch is clamped to the maximum PBS count.
        clearLog();
        applyStimulus(4'd15, 2'd2, 10);
        waitDone(200, 1'b0);
        checkOutput("t6_beats", beat_cnt, 72);
        checkOutput("t6_last_beat", {log_line[71], log_lg[71], log_pbs[71]}, {32'd2, 32'd2, 32'd7});
        freeSlot();

        // Reset in the middle of a batch drops it and restores credit.
        applyStimulus(4'd2, 2'd1, 10);
        tick();
        tick();
        tick();
        tick();
        s_rst_n = 1'b0;
        tick();
        @(negedge clk);
        checkOutput("t7_rst_vld", proc_vld, 0);
        checkOutput("t7_rst_credit", credit, 4);
        tick();
        s_rst_n = 1'b1;
        clearLog();
        applyStimulus(4'd2, 2'd1, 10);
        waitDone(40, 1'b0);
        checkOutput("t7_restart_beat1", {log_line[0], log_lg[0], log_pbs[0], log_first[0]}, {32'd0, 32'd0, 32'd0, 32'd1});
        checkOutput("t7_restart_beats", beat_cnt, 18);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
